// File: rtl/sprite_dma_pkg.sv
// Shared state encodings and default bus addresses for the sprite DMA stage.
package sprite_dma_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HALT  = 3'd1,
        ST_ALIGN = 3'd2,
        ST_READ  = 3'd3,
        ST_WRITE = 3'd4
    } state_e;

    localparam logic [15:0] TRIG_ADDR_DEF = 16'h4014;
    localparam logic [15:0] DEST_ADDR_DEF = 16'h2004;

endpackage

// File: rtl/sprdma_addrgen.sv
// Source page/count registers, next-cycle DMA address mux and terminal-count compare.
module sprdma_addrgen
    import sprite_dma_pkg::*;
#(
    parameter logic [15:0] DEST_ADDR = DEST_ADDR_DEF,
    parameter int          LENGTH    = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [7:0]  load_page,
    input  logic        step,
    input  state_e      state_nxt,
    input  logic [15:0] cpu_a,
    output logic [15:0] addr_nxt,
    output logic        last
);

    localparam logic [8:0] LAST_CNT = 9'(LENGTH - 1);

    logic [7:0] page_q, page_d;
    logic [8:0] cnt_q, cnt_d;

    always_comb begin
        page_d = page_q;
        cnt_d  = cnt_q;
        if (load) begin
            page_d = load_page;
            cnt_d  = 9'd0;
        end else if (step) begin
            cnt_d = cnt_q + 9'd1;
        end
    end

    // Low byte never carries into the page: a transfer wraps within its page.
    always_comb begin
        addr_nxt = 16'h0000;
        case (state_nxt)
            ST_ALIGN: addr_nxt = cpu_a;
            ST_READ:  addr_nxt = {page_d, cnt_d[7:0]};
            ST_WRITE: addr_nxt = DEST_ADDR;
            default:  addr_nxt = 16'h0000;
        endcase
    end

    assign last = (cnt_q == LAST_CNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            page_q <= 8'h00;
            cnt_q  <= 9'd0;
        end else begin
            page_q <= page_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/sprite_dma.sv
// Sprite DMA: snoops the trigger write, stalls the core via RDY and copies one page to DEST_ADDR.
// Build option SPRDMA_ALIGN_EN inserts an ALIGN cycle so every READ lands on a get cycle.
//
// state | meaning
// IDLE  | waiting for a CPU write to TRIG_ADDR
// HALT  | RDY low, waiting for the core to stall on a read
// ALIGN | one dummy bus read to shift READs onto get cycles
// READ  | read source byte {page,cnt[7:0]} into the buffer
// WRITE | write buffer to DEST_ADDR, advance cnt
module sprite_dma
    import sprite_dma_pkg::*;
#(
    parameter logic [15:0] TRIG_ADDR = TRIG_ADDR_DEF,
    parameter logic [15:0] DEST_ADDR = DEST_ADDR_DEF,
    parameter int          LENGTH    = 256
) (
    input  logic        PHI0,
    input  logic        n_RES,
    input  logic [15:0] CPU_A,
    input  logic [7:0]  CPU_D,
    input  logic        CPU_RnW,
    output logic        RDY,
    output logic        DMA_Active,
    output logic [15:0] DMA_A,
    output logic        DMA_RnW,
    input  logic [7:0]  DMA_Din,
    output logic [7:0]  DMA_Dout,
    output logic        Busy
);

    state_e      state_q, state_d;
    logic        parity_q, parity_d;
    logic        rdy_q, rdy_d;
    logic        active_q, active_d;
    logic        busy_q, busy_d;
    logic [15:0] dma_a_q, dma_a_d;
    logic        dma_rnw_q, dma_rnw_d;
    logic [7:0]  dma_dout_q, dma_dout_d;

    logic        load, step, last;
    logic [15:0] addr_nxt;

    sprdma_addrgen #(
        .DEST_ADDR (DEST_ADDR),
        .LENGTH    (LENGTH)
    ) u_addrgen (
        .clk       (PHI0),
        .rst_n     (n_RES),
        .load      (load),
        .load_page (CPU_D),
        .step      (step),
        .state_nxt (state_d),
        .cpu_a     (CPU_A),
        .addr_nxt  (addr_nxt),
        .last      (last)
    );

    always_comb begin
        state_d    = state_q;
        parity_d   = ~parity_q;
        rdy_d      = rdy_q;
        active_d   = active_q;
        busy_d     = busy_q;
        dma_dout_d = dma_dout_q;
        load       = 1'b0;
        step       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!CPU_RnW && CPU_A == TRIG_ADDR) begin
                    load    = 1'b1;
                    busy_d  = 1'b1;
                    rdy_d   = 1'b0;
                    state_d = ST_HALT;
                end
            end
            ST_HALT: begin
                // The core ignores RDY on writes; take the bus only once it stalls on a read.
                if (CPU_RnW) begin
                    active_d = 1'b1;
`ifdef SPRDMA_ALIGN_EN
                    // parity_d is the parity of the cycle that would carry the first READ.
                    state_d = parity_d ? ST_ALIGN : ST_READ;
`else
                    state_d = ST_READ;
`endif
                end
            end
            ST_ALIGN: state_d = ST_READ;
            ST_READ: begin
                dma_dout_d = DMA_Din;
                state_d    = ST_WRITE;
            end
            ST_WRITE: begin
                step = 1'b1;
                if (last) begin
                    state_d  = ST_IDLE;
                    rdy_d    = 1'b1;
                    active_d = 1'b0;
                    busy_d   = 1'b0;
                end else begin
                    state_d = ST_READ;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Bus outputs are registered from the state being entered.
    always_comb begin
        dma_rnw_d = (state_d != ST_WRITE);
        dma_a_d   = active_d ? addr_nxt : dma_a_q;
    end

    always_ff @(posedge PHI0 or negedge n_RES) begin
        if (!n_RES) begin
            state_q    <= ST_IDLE;
            parity_q   <= 1'b0;
            rdy_q      <= 1'b1;
            active_q   <= 1'b0;
            busy_q     <= 1'b0;
            dma_a_q    <= 16'h0000;
            dma_rnw_q  <= 1'b1;
            dma_dout_q <= 8'h00;
        end else begin
            state_q    <= state_d;
            parity_q   <= parity_d;
            rdy_q      <= rdy_d;
            active_q   <= active_d;
            busy_q     <= busy_d;
            dma_a_q    <= dma_a_d;
            dma_rnw_q  <= dma_rnw_d;
            dma_dout_q <= dma_dout_d;
        end
    end

    assign RDY        = rdy_q;
    assign DMA_Active = active_q;
    assign Busy       = busy_q;
    assign DMA_A      = dma_a_q;
    assign DMA_RnW    = dma_rnw_q;
    assign DMA_Dout   = dma_dout_q;

endmodule

// File: tb/tb_sprite_dma.sv
// Bench for sprite_dma: a 256-byte and a 4-byte instance share one CPU bus and are checked
// against a cycle-offset transfer model plus hand-computed expectations.
module tb_sprite_dma;

    localparam int L0 = 256;
    localparam int L1 = 4;
`ifdef SPRDMA_ALIGN_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    logic        PHI0 = 1'b0;
    logic        n_RES = 1'b0;
    logic [15:0] CPU_A = 16'h8000;
    logic [7:0]  CPU_D = 8'h00;
    logic        CPU_RnW = 1'b1;

    logic [1:0]  rdy, act, rnw, busy;
    logic [15:0] da   [2];
    logic [7:0]  dout [2];
    logic [7:0]  din  [2];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 PHI0 = ~PHI0;

    // Memory model: every source byte reads back as its low address byte XOR A5.
    assign din[0] = da[0][7:0] ^ 8'hA5;
    assign din[1] = da[1][7:0] ^ 8'hA5;

    sprite_dma #(.LENGTH(L0)) dut0 (
        .PHI0(PHI0), .n_RES(n_RES), .CPU_A(CPU_A), .CPU_D(CPU_D), .CPU_RnW(CPU_RnW),
        .RDY(rdy[0]), .DMA_Active(act[0]), .DMA_A(da[0]), .DMA_RnW(rnw[0]),
        .DMA_Din(din[0]), .DMA_Dout(dout[0]), .Busy(busy[0])
    );

    sprite_dma #(.LENGTH(L1)) dut1 (
        .PHI0(PHI0), .n_RES(n_RES), .CPU_A(CPU_A), .CPU_D(CPU_D), .CPU_RnW(CPU_RnW),
        .RDY(rdy[1]), .DMA_Active(act[1]), .DMA_A(da[1]), .DMA_RnW(rnw[1]),
        .DMA_Din(din[1]), .DMA_Dout(dout[1]), .Busy(busy[1])
    );

    task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Transfer model: each instance tracks only busy/owning, the page, and the
    // number of bus cycles owned so far; outputs follow from that offset.
    int          len   [2] = '{L0, L1};
    bit          m_busy[2] = '{1'b0, 1'b0};
    bit          m_own [2] = '{1'b0, 1'b0};
    int          m_k   [2] = '{0, 0};
    int          m_al  [2] = '{0, 0};
    logic [7:0]  m_page[2] = '{8'h00, 8'h00};
    logic [15:0] m_ala [2] = '{16'h0000, 16'h0000};
    bit          m_par     = 1'b0;

    always @(posedge PHI0 or negedge n_RES) begin
        if (!n_RES) begin
            m_par = 1'b0;
            for (int i = 0; i < 2; i++) begin
                m_busy[i] = 1'b0;
                m_own[i]  = 1'b0;
                m_k[i]    = 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (!m_busy[i]) begin
                    if (!CPU_RnW && CPU_A == 16'h4014) begin
                        m_busy[i] = 1'b1;
                        m_page[i] = CPU_D;
                    end
                end else if (!m_own[i]) begin
                    if (CPU_RnW) begin
                        m_own[i] = 1'b1;
                        m_k[i]   = 0;
                        // next cycle's parity is !m_par; dummy cycle if that would be a put cycle
                        m_al[i]  = (ALIGN_EN && !m_par) ? 1 : 0;
                        m_ala[i] = CPU_A;
                    end
                end else begin
                    m_k[i]++;
                    if (m_k[i] == 2 * len[i] + m_al[i]) begin
                        m_busy[i] = 1'b0;
                        m_own[i]  = 1'b0;
                    end
                end
            end
            m_par = !m_par;
        end
    end

    always @(negedge PHI0) begin
        if (n_RES) begin
            for (int i = 0; i < 2; i++) begin
                int j;
                chk("cmp_rdy", rdy[i], !m_busy[i]);
                chk("cmp_busy", busy[i], m_busy[i]);
                chk("cmp_active", act[i], m_own[i]);
                if (m_own[i]) begin
                    j = m_k[i] - m_al[i];
                    if (j < 0) begin
                        chk("cmp_align_a", da[i], m_ala[i]);
                        chk("cmp_align_rnw", rnw[i], 1);
                    end else if (j % 2 == 0) begin
                        chk("cmp_read_a", da[i], {m_page[i], 8'(j / 2)});
                        chk("cmp_read_rnw", rnw[i], 1);
                    end else begin
                        chk("cmp_write_a", da[i], 16'h2004);
                        chk("cmp_write_rnw", rnw[i], 0);
                        chk("cmp_write_d", dout[i], 8'((j - 1) / 2) ^ 8'hA5);
                    end
                end
            end
        end
    end

    task automatic cyc(input logic [15:0] a, input logic [7:0] d, input logic rw);
        @(negedge PHI0);
        CPU_A   = a;
        CPU_D   = d;
        CPU_RnW = rw;
    endtask

    task automatic chk_reset_vals(input string tag, input int i);
        chk({tag, "_rdy"}, rdy[i], 1);
        chk({tag, "_active"}, act[i], 0);
        chk({tag, "_rnw"}, rnw[i], 1);
        chk({tag, "_a"}, da[i], 16'h0000);
        chk({tag, "_dout"}, dout[i], 8'h00);
        chk({tag, "_busy"}, busy[i], 0);
    endtask

    initial begin
        int n, owned, nw, nr;
        logic [15:0] last_rd;

        repeat (3) @(negedge PHI0);
        chk_reset_vals("rst0", 0);
        chk_reset_vals("rst1", 1);
        n_RES = 1'b1;
        repeat (2) @(negedge PHI0);

        // Reset while dut0 is reading source byte 5.
        cyc(16'h4014, 8'h03, 1'b0);
        cyc(16'h8000, 8'h00, 1'b1);
        n = 0;
        while (!(act[0] && rnw[0] && da[0] == 16'h0305) && n < 100) begin
            @(negedge PHI0);
            n++;
        end
        chk("reach_cnt5", n < 100, 1);
        #2 n_RES = 1'b0;
        #1 chk_reset_vals("async_rst", 0);
        repeat (2) @(negedge PHI0);
        n_RES = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge PHI0);
            chk("no_resume_active", act[0], 0);
        end

        // Basic transfer from page 02, core reads right after the trigger.
        cyc(16'h4014, 8'h02, 1'b0);
        cyc(16'h8000, 8'h00, 1'b1);
        chk("rdy_low_p1", rdy[0], 0);
        chk("busy_p1", busy[0], 1);
        @(negedge PHI0);
        n = 0; owned = 0; nw = 0;
        while (busy[0] && n < 700) begin
            if (act[0]) owned++;
            if (act[0] && !rnw[0]) begin
                chk("dout_seq", dout[0], 8'(nw) ^ 8'hA5);
                nw++;
            end
`ifndef SPRDMA_ALIGN_EN
            if (n == 0) chk("read_p2_a", da[0], 16'h0200);
            if (n == 1) chk("write_p3_a", da[0], 16'h2004);
            if (n == 1) chk("write_p3_d", dout[0], 8'hA5);
`endif
            @(negedge PHI0);
            n++;
        end
        chk("basic_done", n < 700, 1);
`ifndef SPRDMA_ALIGN_EN
        chk("owned_512", owned, 512);
`else
        chk("owned_align", owned, 2 * L0 + m_al[0]);
`endif
        chk("writes_256", nw, 256);
        chk("rdy_release", rdy[0], 1);
        chk("active_release", act[0], 0);

        // Pending core writes (second is an ignored trigger), then page FF on dut1.
        cyc(16'h4014, 8'hFF, 1'b0);
        cyc(16'h4014, 8'h00, 1'b0);
        chk("pend_w1_act0", act[0], 0);
        chk("pend_w1_act1", act[1], 0);
        cyc(16'h3000, 8'h55, 1'b0);
        chk("pend_w2_act0", act[0], 0);
        chk("pend_w2_act1", act[1], 0);
        cyc(16'h8000, 8'h00, 1'b1);
        chk("pend_rd_act1", act[1], 0);
        @(negedge PHI0);
        chk("pend_own_act1", act[1], 1);
`ifndef SPRDMA_ALIGN_EN
        chk("pend_first_read", da[1], 16'hFF00);
`endif
        n = 0; nr = 0; last_rd = 16'h0000;
        while (busy[1] && n < 50) begin
            if (act[1] && rnw[1] && da[1][15:8] == 8'hFF) begin
                chk("len4_src", da[1], {8'hFF, 8'(nr)});
                last_rd = da[1];
                nr++;
            end
            @(negedge PHI0);
            n++;
        end
        chk("len4_done", n < 50, 1);
        chk("len4_reads", nr, 4);
        chk("len4_last", last_rd, 16'hFF03);
        chk("len4_rdy", rdy[1], 1);
        n = 0;
        while (busy[0] && n < 700) begin
            @(negedge PHI0);
            n++;
        end
        chk("len256_done", n < 700, 1);
        chk("final_rdy0", rdy[0], 1);

        repeat (3) @(negedge PHI0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
